// File: rtl/chunk_serial_adder_if.sv
// rtl/chunk_serial_adder_if.sv - operand/result handshake bundle for chunk_serial_adder
// Carries the optional sub bit when CHUNK_SERIAL_ADDER_SUB_EN is defined.
interface chunk_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`else
  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`endif
endinterface

// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle adder, CHUNK bits per clock via registered carry
// Optional subtract mode enabled by CHUNK_SERIAL_ADDER_SUB_EN.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input logic               clk,
  input logic               rst,
  chunk_serial_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             ovf_next;

  assign base      = 32'(idx) * 32'(CHUNK);
  assign a_chunk   = opa[base +: CHUNK];
  assign b_chunk   = opb[base +: CHUNK];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
  // Carry into the chunk MSB is recovered from its sum bit: a ^ b ^ sum.
  assign ovf_next  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      opa         <= '0;
      opb         <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            opa <= bus.x;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
            opb   <= bus.sub ? ~bus.y : bus.y;
            carry <= bus.sub ? 1'b1 : bus.cin;
`else
            opb   <= bus.y;
            carry <= bus.cin;
`endif
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          s_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry              <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            cout_q      <= chunk_sum[CHUNK];
            ovf_q       <= ovf_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - scoreboard bench for chunk_serial_adder
// Exercises subtract mode too when CHUNK_SERIAL_ADDER_SUB_EN is defined.
module tb_chunk_serial_adder;
  localparam int WIDTH   = 16;
  localparam int CHUNK   = 2;
  localparam int LATENCY = WIDTH / CHUNK;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [WIDTH+1:0] exp_q[$];

  chunk_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result packed as {ovf, cout, s}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic sb);
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             v;
    bb   = sb ? ~b : b;
    cc   = sb ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    v    = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Drives one operand set at a negedge, returns at the negedge after the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic sb);
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
    bus.cin      = c;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    bus.sub      = sb;
`endif
    exp_q.push_back(model(a, b, c, sb));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x        = WIDTH'($urandom);
    bus.y        = WIDTH'($urandom);
    bus.cin      = 1'($urandom);
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    bus.sub      = 1'($urandom);
`endif
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.s !== '0) $display("FAIL reset_s got=%h exp=0000", bus.s); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b00) $display("FAIL reset_cout_ovf got=%b exp=00", {bus.cout, bus.ovf}); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic sb);
    int               cyc;
    logic [WIDTH+1:0] e;
    send(a, b, c, sb);
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL %s in_ready_drop got=%b exp=0", name, bus.in_ready); else pass_cnt++;
    wait_out(cyc);
    total_cnt++; if (cyc != LATENCY) $display("FAIL %s latency got=%0d exp=%0d", name, cyc, LATENCY); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (bus.s !== e[WIDTH-1:0]) $display("FAIL %s s got=%h exp=%h", name, bus.s, e[WIDTH-1:0]); else pass_cnt++;
    total_cnt++; if (bus.cout !== e[WIDTH]) $display("FAIL %s cout got=%b exp=%b", name, bus.cout, e[WIDTH]); else pass_cnt++;
    total_cnt++; if (bus.ovf !== e[WIDTH+1]) $display("FAIL %s ovf got=%b exp=%b", name, bus.ovf, e[WIDTH+1]); else pass_cnt++;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total_cnt++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL %s release got=%b exp=01", name, {bus.out_valid, bus.in_ready}); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int               cyc;
    logic [WIDTH+1:0] e;
    send(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
    wait_out(cyc);
    total_cnt++; if (cyc != LATENCY) $display("FAIL bp_latency got=%0d exp=%0d", cyc, LATENCY); else pass_cnt++;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = WIDTH'($urandom);
      bus.y        = WIDTH'($urandom);
      @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({bus.out_valid, bus.ovf, bus.cout, bus.s} !== {1'b1, e} || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold cycle=%0d got=%b_%h ready=%b exp=1_%h ready=0",
                 i, bus.out_valid, {bus.ovf, bus.cout, bus.s}, bus.in_ready, e);
      else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total_cnt++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL bp_release got=%b exp=01", {bus.out_valid, bus.in_ready}); else pass_cnt++;
    total_cnt++; if (bus.s !== e[WIDTH-1:0]) $display("FAIL bp_s_kept got=%h exp=%h", bus.s, e[WIDTH-1:0]); else pass_cnt++;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH+1:0] dropped;
    send(16'h5555, 16'h5555, 1'b0, 1'b0);
    dropped = exp_q.pop_back();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.s !== '0) $display("FAIL rst_mid_s got=%h exp=0000 (dropped %h)", bus.s, dropped); else pass_cnt++;
    total_cnt++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL rst_mid_flags got=%b exp=01", {bus.out_valid, bus.in_ready}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_add("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      test_add("b2b", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.cin       = 1'b0;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    rst           = 1'b0;
    #1;
    test_reset();
    test_add("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
    test_add("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    test_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    test_add("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    test_add("sub_small", 16'h0005, 16'h0007, 1'b0, 1'b1);
    test_add("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);
    test_add("sub_off", 16'h0005, 16'h0007, 1'b1, 1'b0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/chunk_serial_adder.md
Name: chunk_serial_adder

Overview:
- Parametrised multi-cycle successor to the team's fixed 4-bit chunked ripple adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through a registered inter-chunk carry.
- Operands are latched through a valid/ready handshake; sum, carry-out and signed overflow are returned through a second valid/ready handshake.
- Used in area-constrained datapaths where latency is traded for adder width.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle. Must be at least 1.
- NCHUNK, WIDTH/CHUNK, derived local parameter. Equals the number of CALC cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum.
- cout  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is cleared immediately on rst assertion, independent of clk.
- Reset values:
  - State is IDLE.
  - s=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1, since it is decoded as state==IDLE.
  - Chunk index and carry register are 0.
- State machine: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge (accept edge E0):
    - Latch x, y into operand registers.
    - Load the carry register with cin.
    - Set the chunk index to 0.
    - Move to CALC.
  - With in_valid=0, stay in IDLE.
- CALC:
  - in_ready=0. in_valid is ignored.
  - On each edge, add operand chunk [idx*CHUNK +: CHUNK] plus the carry register.
  - Write that chunk of s; update the carry register.
  - On the last chunk, also record the carry into the MSB for ovf.
  - On the edge that processes idx=NCHUNK-1:
    - Set cout to the final carry.
    - Set ovf.
    - Set out_valid=1.
    - Move to DONE.
  - Otherwise idx increments.
- Latency: out_valid is high in the cycle after edge E(NCHUNK), i.e. NCHUNK cycles after the accept edge. This is 8 for the defaults.
- DONE:
  - out_valid=1.
  - s, cout and ovf hold stable while out_ready=0, for an unbounded time.
  - On an edge with out_ready=1: clear out_valid and go to IDLE. s, cout and ovf keep their last value.
- Throughput: one operation per NCHUNK+2 cycles minimum. No accept in the same cycle as the output handshake.
- Operand capture: x, y and cin may change freely after the accept edge; the result depends only on the latched values.
- s is written chunk by chunk during CALC. It is only meaningful while out_valid=1.
- Reset mid-operation (CALC or DONE): abort immediately and return all outputs to their reset values. There is no residual result, and the next accepted operation computes correctly.
- Arithmetic is modulo 2^WIDTH. The full-width carry chain equals a single-cycle WIDTH-bit add.
- CHUNK=WIDTH is legal: NCHUNK=1, so latency is 1.

Optional Feature:
- Macro: CHUNK_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched at the accept edge.
  - sub=1: the operand register stores ~y and the carry register loads 1, with cin ignored. The block therefore computes x - y.
  - cout is the carry-out (1 = no borrow). ovf is signed subtraction overflow.
  - sub=0: behaviour is identical to the plain adder.
- Undefined: no sub port; addition only.

Test Plan:
- Defaults, x=0x1234, y=0x4321, cin=0:
  - in_ready drops after the accept edge.
  - out_valid rises exactly 8 cycles after the accept edge.
  - s=0x5555, cout=0, ovf=0.
- x=0xFFFF, y=0x0000, cin=1:
  - Carry ripples through all 8 chunks.
  - s=0x0000, cout=1, ovf=0.
- x=0x7FFF, y=0x0001, cin=0: s=0x8000, cout=0, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and x/y toggling throughout.
  - s, cout, ovf, out_valid stay stable and in_ready=0.
  - After out_ready=1 for one edge: out_valid=0 and in_ready=1.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) during CALC at idx=3.
  - s=0, out_valid=0 and in_ready=1 immediately.
  - After release, 0x0001+0x0001 gives s=0x0002.
- With CHUNK_SERIAL_ADDER_SUB_EN:
  - x=0x0005, y=0x0007, sub=1 gives s=0xFFFE, cout=0, ovf=0.
  - x=0x8000, y=0x0001, sub=1 gives s=0x7FFF, cout=1, ovf=1.
